data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares a small number of data-memory channels among the SIMD unit's per-lane LSUs. It sits between the lane LSU request ports and the data memory controller. Pending lane reads and writes are granted round-robin onto NUM_CHANNELS independent channels. Per-lane acknowledge and read data are returned using the LSU valid/ack hold protocol.

## Interface
- NUM_LANES, 16, number of LSU requesters (SIMD lane width)
- NUM_CHANNELS, 4, number of memory channels (1..NUM_LANES)
- ADDR_WIDTH, 7, data memory address width
- DATA_WIDTH, 64, data word width

- clk  in  1  clock, all state rising-edge
- rst  in  1  reset, asynchronous, active-low
- lane_read_valid  in  NUM_LANES  per-lane read request
- lane_write_valid  in  NUM_LANES  per-lane write request
- lane_addr  in  ADDR_WIDTH x NUM_LANES  per-lane address
- lane_write_data  in  DATA_WIDTH x NUM_LANES  per-lane write data
- lane_read_ack  out  NUM_LANES  read complete, held
- lane_write_ack  out  NUM_LANES  write complete, held
- lane_read_data  out  DATA_WIDTH x NUM_LANES  last read result per lane
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_addr  out  ADDR_WIDTH x NUM_CHANNELS  channel address
- mem_write_data  out  DATA_WIDTH x NUM_CHANNELS  channel write data
- mem_read_ready  in  NUM_CHANNELS  read data valid, completes read
- mem_write_ready  in  NUM_CHANNELS  write accepted, completes write
- mem_read_data  in  DATA_WIDTH x NUM_CHANNELS  channel read data
- busy  out  1  any channel not IDLE

## Operation
- Per-channel FSM with states IDLE, ISSUE and RELEASE. Each channel records the lane it owns (owner) and the operation type.
- A lane is claimed when any non-IDLE channel owns it. A lane is pending when it is not claimed and (read_valid | write_valid) is high.
- Grant happens in IDLE.
  - Idle channels are allocated in ascending channel index.
  - Channel c takes the first pending lane at or after rr_ptr (wrapping modulo NUM_LANES) that is not taken by a lower-indexed channel in the same cycle.
  - A granted channel registers owner and op, then moves to ISSUE.
- Op selection: read if lane_read_valid, else write. Both high is a protocol error; a read is issued and write_ack is never raised for it.
- ISSUE drives mem_read_valid or mem_write_valid. mem_addr and mem_write_data follow the owner lane's inputs combinationally.
- ISSUE exits on the matching mem ready:
  - For a read, latch mem_read_data into lane_read_data[owner].
  - Set the owner's ack.
  - Move to RELEASE.
- RELEASE holds the ack high until the owner's valid for that op is sampled low. Then the ack clears and the channel returns to IDLE.
- rr_ptr advances to (highest-priority-order last lane granted this cycle + 1) mod NUM_LANES. It is unchanged when nothing is granted.
- lane_read_data[i] holds its value until the next read completion on lane i.
- If the owner lane drops its valid during ISSUE (protocol violation), the request still completes and passes through RELEASE normally.

## Timing
- Reset values: all acks 0, all mem valids 0, mem_addr 0, mem_write_data 0, lane_read_data 0, busy 0, every channel IDLE, rr_ptr 0.
- Reset asserted mid-transaction aborts immediately; no ack is produced. Lane valids still high after reset release are re-arbitrated from rr_ptr 0.
- Lane valid high in cycle N, with a channel free: mem valid high from N+1.
- Mem ready may be high in the first cycle mem valid is high. Ready sampled in cycle M gives lane ack high from M+1.
- Lane valid sampled low in cycle K gives ack low, and the channel IDLE, in K+1. The earliest regrant of that channel is at the edge ending K+1, which puts ISSUE in K+2.
- Best-case single-request latency: request to ack is 2 cycles.
- When all channels are busy, pending lanes wait with no loss or reordering beyond round-robin order.
- NUM_CHANNELS = NUM_LANES degenerates to a 1:1 mapping, still with round-robin allocation.

## Test plan
- Single read: lane 5 read, addr 0x12, ready the same cycle as valid, data 0xDEAD -> mem_read_valid[0] at N+1, lane_read_ack[5] at N+2, lane_read_data[5]=0xDEAD, ack held until valid drops, then low one cycle later.
- Burst of 16 reads, 4 channels, memory always ready -> lanes 0-3 granted on channels 0-3, then 4-7, 8-11, 12-15. Each group's mem valid rises after the prior group's lanes release. Every lane acked exactly once with the correct data.
- Write with 3-cycle ready delay on lane 2 -> mem_write_valid held 3 cycles with stable addr and data, lane_write_ack[2] the cycle after ready, no read ack.
- Fairness: lanes 0 and 1 re-request continuously with NUM_CHANNELS=1, lane 15 requests -> lane 15 granted within 2 grants, not starved.
- Reset mid-ISSUE: assert rst low while channel 0 is in ISSUE -> all outputs 0 immediately. After release, the still-valid lane is regranted and completes.
- Mixed read/write on lanes 3 and 4, simultaneous -> both serviced in the same cycle on channels 0 and 1, the correct op and ack type per lane.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: groups the lane LSU request/ack signals and the memory channel signals.
// Latency: none, wires only.
// Backpressure: carried by the valid/ack (lane side) and valid/ready (channel side) pairs.
// Ports: lane_* per-lane LSU side, mem_* per-channel memory controller side.
// Modport slave is the arbiter's view; modport master is the surrounding LSUs plus memory controller.
interface data_mem_arbiter_if #(
  parameter int NUM_LANES    = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 64
);
  logic [NUM_LANES-1:0]                     lane_read_valid;
  logic [NUM_LANES-1:0]                     lane_write_valid;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]     lane_addr;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     lane_write_data;
  logic [NUM_LANES-1:0]                     lane_read_ack;
  logic [NUM_LANES-1:0]                     lane_write_ack;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     lane_read_data;

  logic [NUM_CHANNELS-1:0]                  mem_read_valid;
  logic [NUM_CHANNELS-1:0]                  mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                  mem_read_ready;
  logic [NUM_CHANNELS-1:0]                  mem_write_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data;

  modport slave (
    input  lane_read_valid, lane_write_valid, lane_addr, lane_write_data,
    output lane_read_ack, lane_write_ack, lane_read_data,
    output mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
    input  mem_read_ready, mem_write_ready, mem_read_data
  );

  modport master (
    output lane_read_valid, lane_write_valid, lane_addr, lane_write_data,
    input  lane_read_ack, lane_write_ack, lane_read_data,
    input  mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
    output mem_read_ready, mem_write_ready, mem_read_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin grant of per-lane LSU reads/writes onto NUM_CHANNELS memory channels.
// Latency: lane valid -> channel valid 1 cycle; channel ready -> lane ack 1 cycle (best case 2 cycles).
// Backpressure: lanes hold valid while all channels are busy; a channel holds its request until ready.
// Ports: clk, rst (async active-low), bus (slave view of lane + channel signals), busy (any channel active).
module data_mem_arbiter #(
  parameter int NUM_LANES    = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 64
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus,
  output logic              busy
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef logic [LANE_W-1:0] lane_idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} ch_state_t;
  typedef enum logic {OP_WRITE, OP_READ} op_t;

  ch_state_t state_q [NUM_CHANNELS];
  ch_state_t state_d [NUM_CHANNELS];
  lane_idx_t owner_q [NUM_CHANNELS];
  lane_idx_t owner_d [NUM_CHANNELS];
  op_t       op_q    [NUM_CHANNELS];
  op_t       op_d    [NUM_CHANNELS];
  lane_idx_t rr_ptr_q, rr_ptr_d;

  logic [NUM_LANES-1:0]                 read_ack_q, read_ack_d;
  logic [NUM_LANES-1:0]                 write_ack_q, write_ack_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic [NUM_LANES-1:0] claimed;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] taken;
  logic                 found;
  int                   idx;
  lane_idx_t            lane_sel;
  logic                 op_valid;

  logic [NUM_CHANNELS-1:0]                 mem_read_valid_c;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid_c;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_addr_c;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_write_data_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
        op_q[c]    <= OP_READ;
      end
      rr_ptr_q    <= '0;
      read_ack_q  <= '0;
      write_ack_q <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      rr_ptr_q    <= rr_ptr_d;
      read_ack_q  <= read_ack_d;
      write_ack_q <= write_ack_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    rr_ptr_d    = rr_ptr_q;
    read_ack_d  = read_ack_q;
    write_ack_d = write_ack_q;
    read_data_d = read_data_q;
    claimed     = '0;
    taken       = '0;
    found       = 1'b0;
    idx         = 0;
    lane_sel    = '0;
    op_valid    = 1'b0;

    // A lane owned by any active channel (ISSUE or RELEASE) must not be granted again.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] != IDLE) claimed[owner_q[c]] = 1'b1;
    end
    pending = (bus.lane_read_valid | bus.lane_write_valid) & ~claimed;

    // Channels are visited in ascending index, so lower channels pick first and
    // 'taken' keeps a later idle channel from grabbing the same lane this cycle.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        IDLE: begin
          found = 1'b0;
          for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            lane_sel = LANE_W'(idx);
            if (!found && pending[lane_sel] && !taken[lane_sel]) begin
              found            = 1'b1;
              taken[lane_sel]  = 1'b1;
              owner_d[c]       = lane_sel;
              // Read wins when both valids are high; that write is never acked.
              op_d[c]          = bus.lane_read_valid[lane_sel] ? OP_READ : OP_WRITE;
              state_d[c]       = ISSUE;
              // The last grant in the cycle leaves the pointer just past its lane.
              rr_ptr_d         = (idx == NUM_LANES - 1) ? '0 : LANE_W'(idx + 1);
            end
          end
        end
        ISSUE: begin
          if (op_q[c] == OP_READ) begin
            if (bus.mem_read_ready[c]) begin
              read_data_d[owner_q[c]] = bus.mem_read_data[c];
              read_ack_d[owner_q[c]]  = 1'b1;
              state_d[c]              = RELEASE;
            end
          end else if (bus.mem_write_ready[c]) begin
            write_ack_d[owner_q[c]] = 1'b1;
            state_d[c]              = RELEASE;
          end
        end
        RELEASE: begin
          op_valid = (op_q[c] == OP_READ) ? bus.lane_read_valid[owner_q[c]]
                                          : bus.lane_write_valid[owner_q[c]];
          if (!op_valid) begin
            if (op_q[c] == OP_READ) read_ack_d[owner_q[c]]  = 1'b0;
            else                    write_ack_d[owner_q[c]] = 1'b0;
            state_d[c] = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // Channel outputs are zero outside ISSUE; address/data track the owner lane combinationally.
  always_comb begin
    mem_read_valid_c  = '0;
    mem_write_valid_c = '0;
    mem_addr_c        = '0;
    mem_write_data_c  = '0;
    busy              = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] != IDLE) busy = 1'b1;
      if (state_q[c] == ISSUE) begin
        mem_read_valid_c[c]  = (op_q[c] == OP_READ);
        mem_write_valid_c[c] = (op_q[c] == OP_WRITE);
        mem_addr_c[c]        = bus.lane_addr[owner_q[c]];
        mem_write_data_c[c]  = bus.lane_write_data[owner_q[c]];
      end
    end
  end

  assign bus.mem_read_valid  = mem_read_valid_c;
  assign bus.mem_write_valid = mem_write_valid_c;
  assign bus.mem_addr        = mem_addr_c;
  assign bus.mem_write_data  = mem_write_data_c;
  assign bus.lane_read_ack   = read_ack_q;
  assign bus.lane_write_ack  = write_ack_q;
  assign bus.lane_read_data  = read_data_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized lane/memory traffic for data_mem_arbiter.
// Latency: expectations assume request->channel valid 1 cycle, ready->ack 1 cycle.
// Backpressure: memory model stalls ready randomly; lanes hold valid until acked.
module tb_data_mem_arbiter;
  localparam int NL = 16;
  localparam int NC = 4;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam int LAT_LIMIT = 150;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_pass;

  data_mem_arbiter_if #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_arbiter #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.lane_read_valid  = '0;
    bus.lane_write_valid = '0;
    bus.lane_addr        = '0;
    bus.lane_write_data  = '0;
    bus.mem_read_ready   = '0;
    bus.mem_write_ready  = '0;
    bus.mem_read_data    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [63:0] mem_init(input logic [AW-1:0] a);
    return {32'hC0DE_0000 | {25'd0, a}, {25'd0, a} * 32'h9E37_79B9};
  endfunction

  // Randomized-traffic state: lane agents, memory device contents, and the reference
  // view of memory built only from what lanes wrote and had acknowledged.
  int               st       [NL];
  bit               is_rd    [NL];
  int               wait_cyc [NL];
  int               hold     [NL];
  logic [AW-1:0]    lane_a   [NL];
  logic [63:0]      lane_wd  [NL];
  logic [63:0]      phys     [128];
  logic [63:0]      model    [128];
  int               ack_cnt  [NL];
  int               grants   [NC];
  logic [NL-1:0]    prev_ack;
  logic [NL-1:0]    any_wack;
  int               done;
  int               lane;
  logic [63:0]      wd;
  logic [63:0]      rd;
  logic             ack_now;
  logic             other_ack;

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset state, with lanes requesting to show reset dominates.
    rst = 1'b0;
    clear_inputs();
    bus.lane_read_valid = '1;
    for (int i = 0; i < NL; i++) bus.lane_addr[i] = AW'(i + 1);
    tick();
    tick();
    check("rst_read_ack", bus.lane_read_ack, 0);
    check("rst_write_ack", bus.lane_write_ack, 0);
    check("rst_mem_rd_vld", bus.mem_read_valid, 0);
    check("rst_mem_wr_vld", bus.mem_write_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata_or", |bus.mem_write_data, 0);
    check("rst_rdata_or", |bus.lane_read_data, 0);
    check("rst_busy", busy, 0);

    // Single read on lane 5 with ready in the first issue cycle.
    do_reset();
    bus.lane_read_valid[5] = 1'b1;
    bus.lane_addr[5]       = 7'h12;
    tick();
    check("t1_mem_rd_vld", bus.mem_read_valid, 4'b0001);
    check("t1_mem_addr", bus.mem_addr[0], 7'h12);
    check("t1_busy", busy, 1);
    check("t1_no_early_ack", bus.lane_read_ack, 0);
    bus.mem_read_ready[0] = 1'b1;
    bus.mem_read_data[0]  = 64'hDEAD;
    tick();
    check("t1_read_ack", bus.lane_read_ack, 16'h0020);
    check("t1_rdata", bus.lane_read_data[5], 64'hDEAD);
    check("t1_mem_rd_vld_off", bus.mem_read_valid, 0);
    check("t1_no_wack", bus.lane_write_ack, 0);
    bus.mem_read_ready[0] = 1'b0;
    tick();
    check("t1_ack_held", bus.lane_read_ack, 16'h0020);
    bus.lane_read_valid[5] = 1'b0;
    tick();
    check("t1_ack_clear", bus.lane_read_ack, 0);
    check("t1_idle", busy, 0);
    check("t1_rdata_kept", bus.lane_read_data[5], 64'hDEAD);

    // Burst of 16 reads, memory always ready: grants come in groups of four in lane order.
    do_reset();
    check("t2_rdata_reset", bus.lane_read_data[5], 0);
    for (int i = 0; i < NL; i++) begin
      bus.lane_addr[i] = AW'(i * 8);
      ack_cnt[i] = 0;
    end
    for (int c = 0; c < NC; c++) grants[c] = 0;
    bus.lane_read_valid = '1;
    bus.mem_read_ready  = '1;
    prev_ack = '0;
    any_wack = '0;
    done = 0;
    for (int cyc = 0; cyc < 120 && done < NL; cyc++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        if (bus.mem_read_valid[c]) begin
          lane = int'(bus.mem_addr[c]) >> 3;
          check($sformatf("t2_grant_ch%0d", c), lane, 4 * grants[c] + c);
          grants[c]++;
          bus.mem_read_data[c] = mem_init(bus.mem_addr[c]);
        end
      end
      any_wack = any_wack | bus.lane_write_ack;
      for (int i = 0; i < NL; i++) begin
        if (bus.lane_read_ack[i] && !prev_ack[i]) begin
          ack_cnt[i]++;
          check($sformatf("t2_rdata_l%0d", i), bus.lane_read_data[i], mem_init(AW'(i * 8)));
          bus.lane_read_valid[i] = 1'b0;
          done++;
        end
      end
      prev_ack = bus.lane_read_ack;
    end
    tick();
    tick();
    check("t2_all_acked", done, NL);
    for (int i = 0; i < NL; i++) check($sformatf("t2_ack_once_l%0d", i), ack_cnt[i], 1);
    check("t2_no_wack", any_wack, 0);
    check("t2_idle", busy, 0);

    // Write on lane 2 with ready held off for the first two issue cycles.
    do_reset();
    wd = {$urandom, $urandom};
    bus.lane_write_valid[2] = 1'b1;
    bus.lane_addr[2]        = 7'h2A;
    bus.lane_write_data[2]  = wd;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_wr_vld_%0d", k), bus.mem_write_valid, 4'b0001);
      check($sformatf("t3_addr_%0d", k), bus.mem_addr[0], 7'h2A);
      check($sformatf("t3_wdata_%0d", k), bus.mem_write_data[0], wd);
      check($sformatf("t3_wack_wait_%0d", k), bus.lane_write_ack, 0);
      if (k == 2) bus.mem_write_ready[0] = 1'b1;
    end
    tick();
    check("t3_wack", bus.lane_write_ack, 16'h0004);
    check("t3_no_rack", bus.lane_read_ack, 0);
    check("t3_wr_vld_off", bus.mem_write_valid, 0);
    bus.mem_write_ready[0]  = 1'b0;
    bus.lane_write_valid[2] = 1'b0;
    tick();
    check("t3_wack_clear", bus.lane_write_ack, 0);
    check("t3_idle", busy, 0);

    // Simultaneous read on lane 3 and write on lane 4.
    do_reset();
    wd = {$urandom, $urandom};
    rd = {$urandom, $urandom};
    bus.lane_read_valid[3]  = 1'b1;
    bus.lane_addr[3]        = 7'h33;
    bus.lane_write_valid[4] = 1'b1;
    bus.lane_addr[4]        = 7'h44;
    bus.lane_write_data[4]  = wd;
    tick();
    check("t4_rd_vld", bus.mem_read_valid, 4'b0001);
    check("t4_wr_vld", bus.mem_write_valid, 4'b0010);
    check("t4_addr0", bus.mem_addr[0], 7'h33);
    check("t4_addr1", bus.mem_addr[1], 7'h44);
    check("t4_wdata1", bus.mem_write_data[1], wd);
    bus.mem_read_ready[0]  = 1'b1;
    bus.mem_read_data[0]   = rd;
    bus.mem_write_ready[1] = 1'b1;
    tick();
    check("t4_rack", bus.lane_read_ack, 16'h0008);
    check("t4_wack", bus.lane_write_ack, 16'h0010);
    check("t4_rdata", bus.lane_read_data[3], rd);
    clear_inputs();
    tick();
    check("t4_rack_clear", bus.lane_read_ack, 0);
    check("t4_wack_clear", bus.lane_write_ack, 0);

    // Reset asserted while channel 0 is issuing, then the lane is regranted.
    do_reset();
    rd = {$urandom, $urandom};
    bus.lane_read_valid[7] = 1'b1;
    bus.lane_addr[7]       = 7'h77;
    tick();
    check("t5_issue", bus.mem_read_valid, 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    check("t5_abort_vld", bus.mem_read_valid, 0);
    check("t5_abort_addr", bus.mem_addr, 0);
    check("t5_abort_busy", busy, 0);
    tick();
    check("t5_no_ack_in_rst", bus.lane_read_ack, 0);
    rst = 1'b1;
    tick();
    check("t5_regrant", bus.mem_read_valid, 4'b0001);
    check("t5_regrant_addr", bus.mem_addr[0], 7'h77);
    bus.mem_read_ready[0] = 1'b1;
    bus.mem_read_data[0]  = rd;
    tick();
    check("t5_ack", bus.lane_read_ack, 16'h0080);
    check("t5_rdata", bus.lane_read_data[7], rd);
    clear_inputs();
    tick();
    check("t5_ack_clear", bus.lane_read_ack, 0);

    // Randomized traffic: each lane uses its own address slice, so a read must
    // return the value the reference holds from that lane's acknowledged writes.
    do_reset();
    for (int a = 0; a < 128; a++) begin
      phys[a]  = mem_init(AW'(a));
      model[a] = mem_init(AW'(a));
    end
    for (int i = 0; i < NL; i++) st[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        bus.mem_read_ready[c]  = 1'b0;
        bus.mem_write_ready[c] = 1'b0;
        if (bus.mem_read_valid[c] && ($urandom_range(0, 1) == 1)) begin
          bus.mem_read_ready[c] = 1'b1;
          bus.mem_read_data[c]  = phys[bus.mem_addr[c]];
        end
        if (bus.mem_write_valid[c] && ($urandom_range(0, 1) == 1)) begin
          bus.mem_write_ready[c] = 1'b1;
          phys[bus.mem_addr[c]]  = bus.mem_write_data[c];
        end
      end
      for (int i = 0; i < NL; i++) begin
        ack_now   = is_rd[i] ? bus.lane_read_ack[i] : bus.lane_write_ack[i];
        other_ack = is_rd[i] ? bus.lane_write_ack[i] : bus.lane_read_ack[i];
        if (st[i] == 1) begin
          wait_cyc[i]++;
          if (ack_now) begin
            check("rnd_other_ack", other_ack, 0);
            check("rnd_latency_ok", wait_cyc[i] <= LAT_LIMIT, 1);
            if (is_rd[i]) begin
              check($sformatf("rnd_rdata_l%0d", i), bus.lane_read_data[i], model[lane_a[i]]);
            end else begin
              check($sformatf("rnd_wcommit_l%0d", i), phys[lane_a[i]], lane_wd[i]);
              model[lane_a[i]] = lane_wd[i];
            end
            hold[i] = $urandom_range(0, 2);
            st[i]   = 2;
          end else if (wait_cyc[i] > LAT_LIMIT) begin
            check($sformatf("rnd_starved_l%0d", i), wait_cyc[i], LAT_LIMIT);
            bus.lane_read_valid[i]  = 1'b0;
            bus.lane_write_valid[i] = 1'b0;
            st[i] = 4;
          end
        end else if (st[i] == 2) begin
          check("rnd_ack_held", ack_now, 1);
          if (hold[i] == 0) begin
            bus.lane_read_valid[i]  = 1'b0;
            bus.lane_write_valid[i] = 1'b0;
            st[i] = 3;
          end else begin
            hold[i]--;
          end
        end else if (st[i] == 3) begin
          check("rnd_ack_clear", ack_now, 0);
          st[i] = 0;
        end
        if (st[i] == 0 && $urandom_range(0, 3) == 0) begin
          is_rd[i]    = ($urandom_range(0, 1) == 1);
          lane_a[i]   = {4'(i), 3'($urandom_range(0, 7))};
          lane_wd[i]  = {$urandom, $urandom};
          wait_cyc[i] = 0;
          bus.lane_addr[i]        = lane_a[i];
          bus.lane_write_data[i]  = lane_wd[i];
          bus.lane_read_valid[i]  = is_rd[i];
          bus.lane_write_valid[i] = !is_rd[i];
          st[i] = 1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
